midi_byte_writer: RTL and testbench
===================================

# midi_byte_writer

MIDI transmit path: accepts bytes from the Microblaze-side logic over a valid/ready handshake and buffers them in a small FIFO. Serializes each byte onto the MIDI OUT line as a standard 31,250-baud frame: one start bit, 8 data bits LSB first, one stop bit. Counterpart of the MIDI byte receiver; both share the same bit-period constant so that loopback works.

## Interface
- CLKS_PER_BIT, 3200, clock cycles per MIDI bit (100 MHz / 31,250); minimum 2
- FIFO_DEPTH, 4, byte FIFO entries; power of two, minimum 2
- clk  in  1  system clock, 100 MHz
- resetn  in  1  asynchronous, active-low reset
- byte_valid  in  1  byte_value holds a byte to send
- byte_value  in  8  byte to transmit
- byte_ready  out  1  FIFO not full; a byte is accepted on a clk edge with byte_valid && byte_ready
- MIDI_TX  out  1  serial MIDI line, idle high, registered
- busy  out  1  frame in progress or FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently held in FIFO

## Operation
- Reset values: MIDI_TX=1, byte_ready=1, busy=0, fifo_count=0. FIFO is emptied and the serializer goes to IDLE.
- FIFO: write on accept; read (pop) when the serializer loads. byte_ready = (fifo_count != FIFO_DEPTH) and depends only on registered count, never on a same-cycle pop. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Serializer FSM with states IDLE, START, DATA, STOP. It has a bit counter of width $clog2(CLKS_PER_BIT), a 3-bit data index and an 8-bit shift register.
  - IDLE: MIDI_TX=1. If FIFO is non-empty: pop, load shift register, go to START, MIDI_TX<=0.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA and drive bit 0.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 go to STOP and drive 1.
  - STOP: hold 1 for CLKS_PER_BIT cycles. On the last stop cycle, if FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Bytes pass through unmodified. No status or running-status interpretation.
- busy = (state != IDLE) || (fifo_count != 0).
- byte_valid while byte_ready=0: the byte is not taken. The source must hold it until accepted.

## Timing
- Accept on edge N → pop on edge N+1 when idle → MIDI_TX low from edge N+1. First-byte latency is 1 cycle after accept.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Each bit is exactly CLKS_PER_BIT cycles with no jitter.
- Back-to-back frames are contiguous: the start bit of frame k+1 begins on the cycle after the last stop-bit cycle of frame k.
- Accept in the same cycle as a STOP-end pop with an empty FIFO: the byte is written but not seen by that pop. It is sent after 1 idle cycle (IDLE pop next edge).
- busy falls on the edge that ends the final stop bit with an empty FIFO.
- Reset asserted mid-frame: MIDI_TX goes high asynchronously, the frame is truncated, and FIFO contents are discarded. After release, nothing is transmitted until a new accept.

## Structure
- Shared package midi_pkg: MIDI_CLKS_PER_BIT = 3200 (also used by the receiver), frame length constant 10, and the serializer state encoding (IDLE/START/DATA/STOP).
- Sub-module midi_tx_fifo: synchronous FIFO with parameter DEPTH. It has push/pop/din/dout/count/full/empty. Async active-low reset clears pointers and count.
- Top-level holds the FSM, bit-period counter and shift register.

## Test plan
Benches use CLKS_PER_BIT=4 unless stated.
- Reset: hold resetn=0 → MIDI_TX=1, byte_ready=1, busy=0, fifo_count=0. Release with byte_valid=0 for 50 cycles → MIDI_TX stays 1.
- Single byte 0x90 → MIDI_TX from the edge after accept is 4×0 (start), then bits 0,0,0,0,1,0,0,1 each 4 cycles, then 4×1. busy=0 exactly 41 cycles after accept.
- Burst 0x90,0x3C,0x7F on consecutive cycles → 120 contiguous frame cycles, no idle gap between frames. Decoded bytes match in order.
- Overflow, FIFO_DEPTH=4: byte_valid held high with 6 distinct bytes → 5 accepted by cycle 5, byte_ready=0, fifo_count=4. The 6th is accepted on the cycle after the first frame's final pop frees a slot. All 6 are transmitted in order.
- Reset mid-frame: assert resetn=0 during DATA bit 3 of 0x55 with 2 bytes queued → MIDI_TX=1 immediately, fifo_count=0, no further frames.
- Loopback at CLKS_PER_BIT=3200 into the MIDI byte receiver: send 0x00, 0xFF, 0xA5, 0x5A → receiver reports the same four bytes.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI constants and transmit serializer state encoding.
// Used by both the byte writer and the byte receiver so their bit timing always matches.
package midi_pkg;

  localparam int MIDI_CLKS_PER_BIT = 3200;  // 100 MHz / 31,250 baud
  localparam int MIDI_FRAME_BITS   = 10;    // start + 8 data + stop

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/midi_byte_writer_if.sv
// Byte handshake into the MIDI writer: valid/ready, a byte moves on a clk edge with both high.
// The source holds byte_value steady until it has been accepted.
interface midi_byte_writer_if;

  logic       byte_valid;
  logic [7:0] byte_value;
  logic       byte_ready;

  modport master (output byte_valid, output byte_value, input byte_ready);
  modport slave  (input byte_valid, input byte_value, output byte_ready);

endinterface

// File: rtl/midi_tx_fifo.sv
// Byte FIFO for the MIDI writer; dout shows the head entry combinationally, push/pop take effect next edge.
// Push while full and pop while empty are ignored; push and pop together keep the count unchanged.
module midi_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/midi_byte_writer.sv
// MIDI OUT serializer: buffered bytes sent as 1 start, 8 data (LSB first), 1 stop bit, frames back to back.
// Latency: line drops 1 cycle after accept when idle; backpressure: byte_ready low only while the FIFO is full.
module midi_byte_writer
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = MIDI_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  midi_byte_writer_if.slave             byte_if,
  output logic                          MIDI_TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;

  logic          fifo_pop, fifo_full, fifo_empty, push, bit_end;
  logic [7:0]    fifo_dout;

  // Ready comes only from the registered count, never from a same-cycle pop.
  assign byte_if.byte_ready = !fifo_full;
  assign push               = byte_if.byte_valid && !fifo_full;

  midi_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (fifo_pop),
    .din    (byte_if.byte_value),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign MIDI_TX = tx_q;
  assign busy    = (state_q != ST_IDLE) || !fifo_empty;

  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_dout;
          state_d  = ST_START;
          tx_d     = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
          tx_d    = sh_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit when more bytes are waiting.
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sh_d     = fifo_dout;
            state_d  = ST_START;
            tx_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_midi_byte_writer.sv
// Directed bench for midi_byte_writer at 4 clocks per bit and a 4-entry FIFO.
module tb_midi_byte_writer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       resetn;
  logic       midi_tx;
  logic       busy;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] bb [0:5];

  midi_byte_writer_if bif ();

  midi_byte_writer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .byte_if    (bif),
    .MIDI_TX    (midi_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level j cycles into a frame carrying byte b.
  function automatic logic exp_tx(input logic [7:0] b, input int j);
    if (j < CPB)          return 1'b0;
    else if (j < 9 * CPB) return b[(j - CPB) / CPB];
    else                  return 1'b1;
  endfunction

  initial begin
    resetn         = 1'b0;
    bif.byte_valid = 1'b0;
    bif.byte_value = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx",    32'(midi_tx),        32'd1);
    chk("rst_ready", 32'(bif.byte_ready), 32'd1);
    chk("rst_busy",  32'(busy),           32'd0);
    chk("rst_count", 32'(fifo_count),     32'd0);
    resetn = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("idle_tx", 32'(midi_tx), 32'd1);
    end

    // Single byte 0x90: frame starts the edge after accept, busy drops 41 edges after accept
    for (int c = 0; c <= 42; c++) begin
      if (c == 0) begin bif.byte_valid = 1'b1; bif.byte_value = 8'h90; end
      if (c == 1) begin chk("single_cnt", 32'(fifo_count), 32'd1); bif.byte_valid = 1'b0; end
      if (c >= 2 && c <= 41) chk("single_tx", 32'(midi_tx), 32'(exp_tx(8'h90, c - 2)));
      if (c == 41) chk("single_busy_hi", 32'(busy), 32'd1);
      if (c == 42) begin
        chk("single_busy_lo", 32'(busy), 32'd0);
        chk("single_tx_end",  32'(midi_tx), 32'd1);
      end
      @(negedge clk);
    end

    // Accept on the stop-end edge with an empty FIFO: one idle cycle, then the next frame
    for (int c = 0; c <= 83; c++) begin
      if (c == 0) begin bif.byte_valid = 1'b1; bif.byte_value = 8'h12; end
      if (c == 1) bif.byte_valid = 1'b0;
      if (c >= 2 && c <= 41) chk("late_tx0", 32'(midi_tx), 32'(exp_tx(8'h12, c - 2)));
      if (c == 41) begin bif.byte_valid = 1'b1; bif.byte_value = 8'hC3; end
      if (c == 42) begin
        bif.byte_valid = 1'b0;
        chk("late_cnt",  32'(fifo_count), 32'd1);
        chk("late_gap",  32'(midi_tx),    32'd1);
        chk("late_busy", 32'(busy),       32'd1);
      end
      if (c >= 43 && c <= 82) chk("late_tx1", 32'(midi_tx), 32'(exp_tx(8'hC3, c - 43)));
      if (c == 83) chk("late_busy_lo", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // Burst of three on consecutive cycles: 120 contiguous frame cycles
    bb[0] = 8'h90; bb[1] = 8'h3C; bb[2] = 8'h7F;
    for (int c = 0; c <= 122; c++) begin
      if (c <= 2) begin bif.byte_valid = 1'b1; bif.byte_value = bb[c]; end
      if (c == 2) chk("burst_cnt1", 32'(fifo_count), 32'd1);
      if (c == 3) begin bif.byte_valid = 1'b0; chk("burst_cnt2", 32'(fifo_count), 32'd2); end
      if (c >= 2 && c <= 121) chk("burst_tx", 32'(midi_tx), 32'(exp_tx(bb[(c - 2) / 40], (c - 2) % 40)));
      if (c == 122) chk("burst_busy_lo", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // Overflow: six bytes offered back to back into a 4-deep FIFO
    bb[0] = 8'hC1; bb[1] = 8'h02; bb[2] = 8'hF4; bb[3] = 8'h38; bb[4] = 8'h5D; bb[5] = 8'h6E;
    for (int c = 0; c <= 242; c++) begin
      if (c <= 4) begin bif.byte_valid = 1'b1; bif.byte_value = bb[c]; end
      if (c == 5) begin
        chk("ovf_cnt_full", 32'(fifo_count),     32'd4);
        chk("ovf_ready_lo", 32'(bif.byte_ready), 32'd0);
        bif.byte_value = bb[5];
      end
      if (c == 41) chk("ovf_ready_hold", 32'(bif.byte_ready), 32'd0);
      if (c == 42) begin
        chk("ovf_ready_hi", 32'(bif.byte_ready), 32'd1);
        chk("ovf_cnt_pop",  32'(fifo_count),     32'd3);
      end
      if (c == 43) begin
        chk("ovf_cnt_6th", 32'(fifo_count), 32'd4);
        bif.byte_valid = 1'b0;
      end
      if (c >= 2 && c <= 241) chk("ovf_tx", 32'(midi_tx), 32'(exp_tx(bb[(c - 2) / 40], (c - 2) % 40)));
      if (c == 242) begin
        chk("ovf_busy_lo", 32'(busy),       32'd0);
        chk("ovf_cnt_end", 32'(fifo_count), 32'd0);
      end
      @(negedge clk);
    end

    // Reset during data bit 3 of 0x55 with two bytes queued
    for (int c = 0; c <= 21; c++) begin
      if (c == 0) begin bif.byte_valid = 1'b1; bif.byte_value = 8'h55; end
      if (c == 1) bif.byte_value = 8'h11;
      if (c == 2) bif.byte_value = 8'h22;
      if (c == 3) bif.byte_valid = 1'b0;
      if (c >= 2) chk("mrst_tx", 32'(midi_tx), 32'(exp_tx(8'h55, c - 2)));
      if (c == 21) chk("mrst_cnt_pre", 32'(fifo_count), 32'd2);
      if (c < 21) @(negedge clk);
    end
    resetn = 1'b0;
    #1;
    chk("mrst_tx_async", 32'(midi_tx),        32'd1);
    chk("mrst_cnt",      32'(fifo_count),     32'd0);
    chk("mrst_busy",     32'(busy),           32'd0);
    chk("mrst_ready",    32'(bif.byte_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("post_rst_tx",   32'(midi_tx), 32'd1);
      chk("post_rst_busy", 32'(busy),    32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
